// File: rtl/burst_mem_if.sv
// Command / write-beat / read-beat bus between a burst_mem and the master driving it.
interface burst_mem_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
);
  localparam int LEN_WIDTH = $clog2(MAX_BURST) + 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  err_inject;
  logic                  rd_valid;
  logic                  rd_last;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  cmd_err;
  logic                  parity_err;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, data_in, err_inject,
    output cmd_ready, wr_ready, rd_valid, rd_last, data_out, busy, cmd_err, parity_err
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, data_in, err_inject,
    input  cmd_ready, wr_ready, rd_valid, rd_last, data_out, busy, cmd_err, parity_err
  );
endinterface

// File: rtl/burst_mem.sv
// Single-port burst memory with self-clear after reset and auto-incrementing, wrapping bursts.
// Optional per-word even parity with error injection: define BURST_MEM_PARITY_EN.
module burst_mem #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input logic       clk,
  input logic       rst,
  burst_mem_if.slave bus
);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int LEN_WIDTH = $clog2(MAX_BURST) + 1;
`ifdef BURST_MEM_PARITY_EN
  localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
  localparam int WORD_WIDTH = DATA_WIDTH;
`endif

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WR    = 2'd2;
  localparam logic [1:0] ST_RD    = 2'd3;

  // A burst must never revisit an address, so it cannot exceed the array.
  if (MAX_BURST < 1 || MAX_BURST > DEPTH) begin : g_badBurst
    $error("burst_mem: MAX_BURST must lie in 1..DEPTH");
  end

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clrCnt_q, clrCnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic                  pipeValid_q, pipeLast_q;
  logic                  rdValid_q, rdLast_q, cmdErr_q;
  logic [DATA_WIDTH-1:0] dataOut_q;
  logic [WORD_WIDTH-1:0] memQ_q;
  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic                  cmdFire, cmdLegal, wrFire, rdIssue, lastBeat, memWe;
  logic [ADDR_WIDTH-1:0] memWaddr;
  logic [WORD_WIDTH-1:0] memWdata, wrWord;

  assign cmdFire  = (state_q == ST_IDLE) && bus.cmd_valid;
  assign cmdLegal = (bus.cmd_len != '0) && (bus.cmd_len <= LEN_WIDTH'(MAX_BURST));
  assign wrFire   = (state_q == ST_WR) && bus.wr_valid;
  assign rdIssue  = (state_q == ST_RD);
  assign lastBeat = (beats_q == LEN_WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    case (state_q)
      ST_CLEAR: begin
        clrCnt_d = clrCnt_q + 1'b1;
        if (clrCnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmdFire && cmdLegal) begin
          addr_d  = bus.cmd_addr;
          beats_d = bus.cmd_len;
          state_d = bus.cmd_write ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        if (bus.wr_valid) begin
          addr_d  = addr_q + 1'b1;
          beats_d = beats_q - 1'b1;
          if (lastBeat) state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        addr_d  = addr_q + 1'b1;
        beats_d = beats_q - 1'b1;
        if (lastBeat) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

`ifdef BURST_MEM_PARITY_EN
  assign wrWord = {(^bus.data_in) ^ bus.err_inject, bus.data_in};
`else
  logic unusedErrInject;
  assign unusedErrInject = bus.err_inject;
  assign wrWord          = bus.data_in;
`endif

  // The single port is shared by the clear sweep and write beats; reset blocks any write.
  assign memWe    = !rst && ((state_q == ST_CLEAR) || wrFire);
  assign memWaddr = (state_q == ST_CLEAR) ? clrCnt_q : addr_q;
  assign memWdata = (state_q == ST_CLEAR) ? '0 : wrWord;

  always_ff @(posedge clk) begin
    if (memWe) mem[memWaddr] <= memWdata;
    memQ_q <= mem[addr_q];
  end

  // Read path is two stages deep: registered array output, then the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clrCnt_q    <= '0;
      addr_q      <= '0;
      beats_q     <= '0;
      pipeValid_q <= 1'b0;
      pipeLast_q  <= 1'b0;
      rdValid_q   <= 1'b0;
      rdLast_q    <= 1'b0;
      dataOut_q   <= '0;
      cmdErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clrCnt_q    <= clrCnt_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      pipeValid_q <= rdIssue;
      pipeLast_q  <= rdIssue && lastBeat;
      rdValid_q   <= pipeValid_q;
      rdLast_q    <= pipeLast_q;
      cmdErr_q    <= cmdFire && !cmdLegal;
      if (pipeValid_q) dataOut_q <= memQ_q[DATA_WIDTH-1:0];
    end
  end

`ifdef BURST_MEM_PARITY_EN
  logic parityErr_q;
  always_ff @(posedge clk) begin
    if (rst) parityErr_q <= 1'b0;
    else     parityErr_q <= pipeValid_q && ((^memQ_q[DATA_WIDTH-1:0]) != memQ_q[DATA_WIDTH]);
  end
  assign bus.parity_err = parityErr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.wr_ready  = (state_q == ST_WR);
  assign bus.rd_valid  = rdValid_q;
  assign bus.rd_last   = rdLast_q;
  assign bus.data_out  = dataOut_q;
  assign bus.cmd_err   = cmdErr_q;
endmodule
